// File: rtl/eth_tx_stream_packer.sv
// eth_tx_stream_packer
//   Turns 32-bit little-endian uDMA TX words into one byte-wide AXI-stream
//   frame for the MAC transmit input. The frame length in bytes is captured
//   at start. tlast marks the final byte. A software abort ends the frame
//   early with tlast=1 and tuser=1, so the MAC FIFO drops it as a bad frame.
//
// Ports
//   clk, rst                 MAC logic clock; synchronous active-high reset
//   cfg_frame_len            frame length in bytes (captured on accepted start)
//   cfg_start, cfg_abort     single-cycle control requests
//   busy, done, aborted      status; done pulses one cycle, aborted qualifies it
//   word_data/valid/ready    uDMA TX word input (byte 0 = bits [7:0])
//   tx_axis_*                byte stream to the MAC
//   stat_frames, stat_bytes  statistics counters
//
// Build option
//   ETH_TX_PACKER_STATS_EN   when defined, stat_frames counts normally completed
//                            frames and stat_bytes counts byte handshakes. When
//                            undefined, both ports are tied to zero.
module eth_tx_stream_packer #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_WIDTH-1:0] cfg_frame_len,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  input  logic [31:0]          word_data,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic [7:0]           tx_axis_tdata,
  output logic                 tx_axis_tvalid,
  input  logic                 tx_axis_tready,
  output logic                 tx_axis_tlast,
  output logic                 tx_axis_tuser,
  output logic [31:0]          stat_frames,
  output logic [31:0]          stat_bytes
);

  // ceil(len/4) for a LEN_WIDTH-bit length always fits in LEN_WIDTH-1 bits
  localparam int WCNT_W = LEN_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, LAST_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [WCNT_W-1:0]    words_left_q, words_left_d;
  logic [31:0]          buf_q, buf_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic [LEN_WIDTH:0]   len_plus3;
  logic [WCNT_W-1:0]    words_init;
  logic                 term;
  logic                 tvalid_int;
  logic                 last_int;
  logic                 hs;
  logic                 finish;
  logic                 load;

  // Handshake and output decode
  always_comb begin
    len_plus3  = {1'b0, cfg_frame_len} + (LEN_WIDTH + 1)'(3);
    words_init = len_plus3[LEN_WIDTH:2];
    // After an abort, the terminating byte is the first one that was not
    // already on the bus when the abort arrived (hold_q covers that byte).
    term       = (state_q == LAST_DRAIN) && !hold_q;
    // With no buffered data left, the terminating byte re-presents the last
    // byte sent, because byte_idx is parked on it.
    tvalid_int = (state_q != IDLE) && (buf_valid_q || term);
    last_int   = (rem_q == LEN_WIDTH'(1)) || term;
    hs         = tvalid_int && tx_axis_tready;
    finish     = hs && last_int;
    // Refill in the same cycle the last byte of the buffered word leaves,
    // so sustained streaming has no bubbles.
    word_ready = (state_q == RUN) && (words_left_q != '0) &&
                 (!buf_valid_q || ((byte_idx_q == 2'd3) && hs));
    load       = word_ready && word_valid;

    busy           = (state_q != IDLE);
    done           = done_q;
    aborted        = aborted_q;
    tx_axis_tvalid = tvalid_int;
    tx_axis_tdata  = tvalid_int ? buf_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
    tx_axis_tlast  = tvalid_int && last_int;
    tx_axis_tuser  = tvalid_int && term;
  end

  // Next-state
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    words_left_d = words_left_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    byte_idx_d   = byte_idx_q;
    hold_d       = hold_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start && (cfg_frame_len != '0)) begin
          state_d      = RUN;
          rem_d        = cfg_frame_len;
          words_left_d = words_init;
          buf_valid_d  = 1'b0;
          byte_idx_d   = 2'd0;
          hold_d       = 1'b0;
        end
      end
      default: begin
        if (finish) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          aborted_d   = term;
          buf_valid_d = 1'b0;
          hold_d      = 1'b0;
        end else begin
          if (hs) begin
            rem_d  = rem_q - LEN_WIDTH'(1);
            hold_d = 1'b0;
            if (byte_idx_q == 2'd3) begin
              buf_valid_d = 1'b0;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
          if (load) begin
            buf_d        = word_data;
            buf_valid_d  = 1'b1;
            byte_idx_d   = 2'd0;
            words_left_d = words_left_q - WCNT_W'(1);
          end
          // An abort that coincides with the normal final handshake is
          // overridden by finish above, so the frame completes normally.
          if ((state_q == RUN) && cfg_abort) begin
            state_d = LAST_DRAIN;
            hold_d  = tvalid_int && !hs;
          end
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      words_left_q <= '0;
      buf_valid_q  <= 1'b0;
      byte_idx_q   <= 2'd0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      words_left_q <= words_left_d;
      buf_valid_q  <= buf_valid_d;
      byte_idx_q   <= byte_idx_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

`ifdef ETH_TX_PACKER_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_bytes_q, stat_bytes_d;

  always_comb begin
    stat_frames_d = stat_frames_q + {31'd0, (finish && !term)};
    stat_bytes_d  = stat_bytes_q + {31'd0, hs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_q <= '0;
      stat_bytes_q  <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_bytes_q  <= stat_bytes_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_bytes  = stat_bytes_q;
`else
  assign stat_frames = 32'd0;
  assign stat_bytes  = 32'd0;
`endif

endmodule

// File: tb/tb_eth_tx_stream_packer.sv
// Directed testbench for eth_tx_stream_packer.
module tb_eth_tx_stream_packer;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_frame_len;
  logic          cfg_start, cfg_abort;
  logic          busy, done, aborted;
  logic [31:0]   word_data;
  logic          word_valid, word_ready;
  logic [7:0]    tx_axis_tdata;
  logic          tx_axis_tvalid, tx_axis_tready, tx_axis_tlast, tx_axis_tuser;
  logic [31:0]   stat_frames, stat_bytes;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wtake, ndone = 0, stab_err, first_take, done_cyc;
  logic last_aborted, done_tvalid, done_busy;
  logic feed_en, gap_en, tr_toggle, stall_q;
  logic [9:0] stall_val;
  logic [31:0] wq[$];
  logic [9:0]  bq[$];
  logic [9:0]  exp_q[$];
  int          hq[$];

  always #4 clk = ~clk;

  eth_tx_stream_packer #(.LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cfg_frame_len(cfg_frame_len), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .busy(busy), .done(done), .aborted(aborted),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
    .tx_axis_tready(tx_axis_tready), .tx_axis_tlast(tx_axis_tlast),
    .tx_axis_tuser(tx_axis_tuser),
    .stat_frames(stat_frames), .stat_bytes(stat_bytes)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic update_feed();
    logic in_gap;
    in_gap = gap_en && (wtake >= 1) && (cyc >= first_take + 3) && (cyc <= first_take + 7);
    word_valid = feed_en && (wq.size() != 0) && !in_gap;
    word_data  = (wq.size() != 0) ? wq[0] : 32'h0;
  endtask

  // One clock cycle: observe at the falling edge, update drivers after the rising edge.
  task automatic step();
    logic take;
    take = 1'b0;
    @(negedge clk);
    if (stall_q) begin
      if (!tx_axis_tvalid || ({tx_axis_tuser, tx_axis_tlast, tx_axis_tdata} != stall_val))
        stab_err++;
    end
    stall_q   = tx_axis_tvalid && !tx_axis_tready && !rst;
    stall_val = {tx_axis_tuser, tx_axis_tlast, tx_axis_tdata};
    if (tx_axis_tvalid && tx_axis_tready && !rst) begin
      bq.push_back({tx_axis_tuser, tx_axis_tlast, tx_axis_tdata});
      hq.push_back(cyc + 1);
    end
    if (word_valid && word_ready && !rst) begin
      take = 1'b1;
      wtake++;
      if (wtake == 1) first_take = cyc + 1;
    end
    if (done && !rst) begin
      ndone++;
      last_aborted = aborted;
      done_cyc     = cyc;
      done_tvalid  = tx_axis_tvalid;
      done_busy    = busy;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (take) void'(wq.pop_front());
    if (tr_toggle) tx_axis_tready = !tx_axis_tready;
    update_feed();
  endtask

  task automatic new_test();
    bq.delete(); hq.delete(); exp_q.delete(); wq.delete();
    wtake = 0; stab_err = 0; first_take = 0; stall_q = 1'b0;
    feed_en = 1'b0; gap_en = 1'b0; tr_toggle = 1'b0;
    update_feed();
  endtask

  task automatic push_words(input logic [7:0] base, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [7:0] b;
      b = 8'(int'(base) + 4 * w);
      wq.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    update_feed();
  endtask

  task automatic build_exp(input logic [7:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, (i == n - 1), 8'(int'(base) + i)});
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_nbytes"}, bq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bq.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(bq[i]), 32'(exp_q[i]));
  endtask

  task automatic start_frame(input logic [LW-1:0] len);
    cfg_frame_len = len;
    cfg_start     = 1'b1;
    update_feed();
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n0;
    n0 = ndone;
    for (int i = 0; i < bound && ndone == n0; i++) step();
    check({tag, "_done"}, ndone - n0, 1);
  endtask

  task automatic run_to_bytes(input int n);
    for (int i = 0; i < 200 && bq.size() < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [7:0] t2b [5];
    rst = 1'b1; cfg_frame_len = '0; cfg_start = 1'b0; cfg_abort = 1'b0;
    tx_axis_tready = 1'b0; last_aborted = 1'b0; done_tvalid = 1'b0; done_busy = 1'b0;
    done_cyc = 0;
    new_test();
    repeat (3) step();

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_aborted", 32'(aborted), 0);
    check("rst_word_ready", 32'(word_ready), 0);
    check("rst_tvalid", 32'(tx_axis_tvalid), 0);
    check("rst_tdata", 32'(tx_axis_tdata), 0);
    check("rst_tlast", 32'(tx_axis_tlast), 0);
    check("rst_tuser", 32'(tx_axis_tuser), 0);
    check("rst_stat_frames", stat_frames, 0);
    check("rst_stat_bytes", stat_bytes, 0);
    rst = 1'b0;
    step();

    // len=8, two words, back-to-back bytes
    new_test();
    wq.push_back(32'h44332211); wq.push_back(32'h88776655);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd8);
    check("t1_busy_after_start", 32'(busy), 1);
    check("t1_wready_after_start", 32'(word_ready), 1);
    step();
    check("t1_first_tvalid", 32'(tx_axis_tvalid), 1);
    check("t1_first_tdata", 32'(tx_axis_tdata), 32'h11);
    wait_done("t1", 40);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, (i == 7), 8'(17 * (i + 1))});
    compare_q("t1");
    check("t1_span", (hq.size() >= 8) ? hq[7] - hq[0] : -1, 7);
    check("t1_done_cycle", done_cyc, (hq.size() != 0) ? hq[hq.size() - 1] : -1);
    check("t1_done_tvalid", 32'(done_tvalid), 0);
    check("t1_done_busy", 32'(done_busy), 0);
    check("t1_aborted", 32'(last_aborted), 0);
    check("t1_words", wtake, 2);

    // len=5: upper bytes of the second word dropped, no extra fetch
    new_test();
    wq.push_back(32'hDDCCBBAA); wq.push_back(32'h000000EE); wq.push_back(32'h5A5A5A5A);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd5);
    wait_done("t2", 40);
    t2b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, (i == 4), t2b[i]});
    compare_q("t2");
    check("t2_words", wtake, 2);
    check("t2_aborted", 32'(last_aborted), 0);

    // len=12 with tready toggling every cycle
    new_test();
    push_words(8'h20, 3);
    feed_en = 1'b1; tx_axis_tready = 1'b1; tr_toggle = 1'b1;
    start_frame(16'd12);
    wait_done("t3a", 80);
    tr_toggle = 1'b0; tx_axis_tready = 1'b1;
    build_exp(8'h20, 12);
    compare_q("t3a");
    check("t3a_span", (hq.size() >= 12) ? hq[11] - hq[0] : -1, 22);
    check("t3a_stable", stab_err, 0);

    // len=12 with word_valid low for 5 cycles right when the refill is due
    new_test();
    push_words(8'h30, 3);
    feed_en = 1'b1; gap_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd12);
    wait_done("t3b", 80);
    build_exp(8'h30, 12);
    compare_q("t3b");
    check("t3b_gap", (hq.size() >= 5) ? hq[4] - hq[3] : -1, 6);
    check("t3b_span", (hq.size() >= 12) ? hq[11] - hq[0] : -1, 16);
    check("t3b_words", wtake, 3);

    // len=64, abort while byte 0x0A is stalled
    new_test();
    push_words(8'h00, 16);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd64);
    run_to_bytes(10);
    tx_axis_tready = 1'b0;
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("t4_hold_tvalid", 32'(tx_axis_tvalid), 1);
    check("t4_hold_tdata", 32'(tx_axis_tdata), 32'h0A);
    check("t4_hold_tlast", 32'(tx_axis_tlast), 0);
    check("t4_hold_tuser", 32'(tx_axis_tuser), 0);
    check("t4_wready_after_abort", 32'(word_ready), 0);
    step(); step();
    check("t4_hold2_tdata", 32'(tx_axis_tdata), 32'h0A);
    check("t4_wready2", 32'(word_ready), 0);
    tx_axis_tready = 1'b1;
    wait_done("t4", 20);
    build_exp(8'h00, 12);
    exp_q[11] = {1'b1, 1'b1, 8'h0B};
    compare_q("t4");
    check("t4_aborted", 32'(last_aborted), 1);
    check("t4_words", wtake, 3);
    check("t4_stable", stab_err, 0);

    // Abort in the same cycle as the normal tlast handshake
    new_test();
    wq.push_back(32'hA3A2A1A0);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd4);
    run_to_bytes(3);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    wait_done("t4b", 10);
    build_exp(8'hA0, 4);
    compare_q("t4b");
    check("t4b_aborted", 32'(last_aborted), 0);

    // Abort before any data: a stale terminating byte is presented
    new_test();
    tx_axis_tready = 1'b0;
    start_frame(16'd8);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    check("t4c_tvalid", 32'(tx_axis_tvalid), 1);
    check("t4c_tlast", 32'(tx_axis_tlast), 1);
    check("t4c_tuser", 32'(tx_axis_tuser), 1);
    check("t4c_wready", 32'(word_ready), 0);
    tx_axis_tready = 1'b1;
    wait_done("t4c", 10);
    check("t4c_aborted", 32'(last_aborted), 1);
    check("t4c_nbytes", bq.size(), 1);
    check("t4c_words", wtake, 0);

    // Start with len=0 is ignored
    new_test();
    n0 = ndone;
    start_frame(16'd0);
    check("t5_len0_busy", 32'(busy), 0);
    repeat (3) step();
    check("t5_len0_nodone", ndone - n0, 0);
    check("t5_len0_wready", 32'(word_ready), 0);

    // Start while busy is ignored, length stays 8
    new_test();
    push_words(8'h40, 2);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd8);
    step(); step();
    cfg_frame_len = 16'd4;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_done("t5", 40);
    build_exp(8'h40, 8);
    compare_q("t5");
    check("t5_words", wtake, 2);

    // Reset mid-frame while a byte is stalled
    new_test();
    push_words(8'h50, 2);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd8);
    run_to_bytes(3);
    tx_axis_tready = 1'b0;
    rst = 1'b1;
    step();
    check("t6_tvalid", 32'(tx_axis_tvalid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_wready", 32'(word_ready), 0);
    check("t6_tdata", 32'(tx_axis_tdata), 0);
    rst = 1'b0;
    feed_en = 1'b0;
    update_feed();
    n0 = ndone;
    repeat (4) step();
    check("t6_nodone", ndone - n0, 0);

    // Two normal 8-byte frames after reset
    new_test();
    push_words(8'h60, 2);
    feed_en = 1'b1; tx_axis_tready = 1'b1;
    start_frame(16'd8);
    wait_done("t7a", 40);
    new_test();
    push_words(8'h70, 2);
    feed_en = 1'b1;
    start_frame(16'd8);
    wait_done("t7b", 40);
    step();
`ifdef ETH_TX_PACKER_STATS_EN
    check("t7_stat_frames", stat_frames, 2);
    check("t7_stat_bytes", stat_bytes, 16);
`else
    check("t7_stat_frames", stat_frames, 0);
    check("t7_stat_bytes", stat_bytes, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
